tick_gen: RTL
=============

Name: tick_gen

Overview:
- Parametrised, multi-channel periodic/one-shot tick generator.
- Successor to the fixed divide-by-15 enable counter.
- Each channel produces a one-clock-wide strobe every (period+1) clocks.
- Periods are runtime-programmable per channel; each channel has its own run control and periodic/one-shot mode.
- Drives game timing: sprite animation rate, duck movement steps, round timers.

Parameters:
- NUM_CH, 4, number of independent channels (1..16).
- CNT_W, 8, counter/period width in bits.
- DEFAULT_PERIOD, 14, reset value of every period register and counter (gives 15-clock period).
- PRESCALE_W, 8, prescaler width (used only with the optional feature).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- run  in  NUM_CH  per-channel level enable.
- oneshot  in  NUM_CH  per-channel mode: 1 = one-shot, 0 = periodic; sampled on IDLE->COUNT.
- wr_en  in  1  period write strobe.
- wr_ch  in  $clog2(NUM_CH) (min 1)  target channel of the write.
- wr_period  in  CNT_W  new period value.
- tick  out  NUM_CH  one-clock strobe per channel.
- done  out  NUM_CH  one-shot channel has fired and is parked.
- busy  out  NUM_CH  channel in COUNT state.
- prescale_div  in  PRESCALE_W  prescaler divisor; present only with TICK_GEN_PRESCALE_EN.

Behaviour:
- Reset (async assert, sync release):
  - all channels IDLE; count = period_reg = DEFAULT_PERIOD.
  - tick = done = busy = 0; mode latch = 0.
- Per-channel FSM, all transitions on the rising clk edge:
  - IDLE: count held at period_reg. If run=1: -> COUNT, count <= period_reg, latch oneshot.
  - COUNT, count != 0: count <= count-1.
  - COUNT, count == 0: tick <= 1 for exactly one cycle, count <= period_reg. Periodic mode stays in COUNT; one-shot mode -> DONE.
  - COUNT, run=0: -> IDLE immediately, count reloaded, no tick. run=0 takes priority over count==0.
  - DONE: done=1, tick=0, count frozen. run=0 -> IDLE, done cleared. Re-arming needs run low for at least one cycle.
- Timing:
  - run sampled high at edge 0 -> tick high in the cycle after edge P+1.
  - Periodic repeat every P+1 clocks.
  - P=0 -> tick every cycle (continuous high) in periodic mode.
- Period writes:
  - wr_en=1 writes period_reg[wr_ch]; wr_ch >= NUM_CH is ignored.
  - No effect on a running count; the new value takes effect at the next reload.
  - Write in the same cycle as a reload (count==0, or IDLE->COUNT): the new value is loaded.
  - Write to an IDLE channel: count follows on the next cycle.
- Arithmetic: unsigned CNT_W; decrement never below 0 (reload occurs at 0, so no wrap).
- busy = (state == COUNT), registered.
- Channels are fully independent; simultaneous ticks are allowed.

Optional Feature:
- Macro: TICK_GEN_PRESCALE_EN.
- Defined:
  - Adds a shared free-running prescaler counting prescale_div..0, emitting a strobe at 0.
  - COUNT-state decrement/reload happens only on strobe cycles; tick remains one clk wide. Period becomes (P+1)*(prescale_div+1) clocks.
  - Prescaler resets to prescale_div on reset_n.
  - run=0 and FSM transitions still act every clk.
- Undefined: prescale_div port absent; decrement every clk.

Decomposition:
- Package tick_gen_pkg: channel state enum (IDLE, COUNT, DONE), default width constants, DEFAULT_PERIOD constant.
- Sub-module tick_gen_ch: one channel (FSM, counter, period register), instantiated NUM_CH times via generate.
- Prescaler and write decode live in the top-level tick_gen.

Test Plan:
- Reset defaults, ch0 run=1 periodic: tick[0] pulses at edges 15, 30, 45; each pulse 1 cycle wide; busy[0]=1.
- Write ch1 period=3 while idle, run=1: ticks every 4 clocks. Write 9 mid-count: current interval stays 4, next interval 10.
- ch2 oneshot=1, period=5, run=1: single tick 6 clocks after the run edge, then done[2]=1. Hold run: no more ticks. Drop run 1 cycle and reassert: fires again.
- Period=0 periodic: tick high every cycle. Deassert run with count==0: no tick that cycle, channel IDLE.
- reset_n pulled low mid-count on all channels: outputs 0 immediately, asynchronously. Counts and periods return to 14 after release.
- With TICK_GEN_PRESCALE_EN, prescale_div=3, period=2: ticks every 12 clocks, 1 clk wide.

Source files
------------

// File: rtl/tick_gen_pkg.sv
// rtl/tick_gen_pkg.sv - channel state type and default constants for tick_gen
package tick_gen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } ch_state_e;

    localparam int DEF_NUM_CH     = 4;
    localparam int DEF_CNT_W      = 8;
    localparam int DEF_PERIOD     = 14;
    localparam int DEF_PRESCALE_W = 8;

    // Channel-select width; a single-channel build still gets a 1-bit port.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_gen_ch.sv
// rtl/tick_gen_ch.sv - one tick channel: run/one-shot FSM, down-counter, period register
module tick_gen_ch
    import tick_gen_pkg::*;
#(
    parameter int CNT_W          = DEF_CNT_W,
    parameter int DEFAULT_PERIOD = DEF_PERIOD
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             run,
    input  logic             oneshot,
    input  logic             strobe,
    input  logic             wr_hit,
    input  logic [CNT_W-1:0] wr_period,
    output logic             tick,
    output logic             done,
    output logic             busy
);

    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             mode_q, mode_d;
    logic             tick_q, tick_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    always_comb begin
        // A write landing on a reload cycle is picked up by that reload.
        period_d = wr_hit ? wr_period : period_q;
        state_d  = state_q;
        count_d  = count_q;
        mode_d   = mode_q;
        tick_d   = 1'b0;
        case (state_q)
            IDLE: begin
                count_d = period_q;
                if (run) begin
                    state_d = COUNT;
                    count_d = period_d;
                    mode_d  = oneshot;
                end
            end
            COUNT: begin
                if (!run) begin
                    state_d = IDLE;
                    count_d = period_d;
                end else if (strobe) begin
                    if (count_q == '0) begin
                        tick_d  = 1'b1;
                        count_d = period_d;
                        if (mode_q) begin
                            state_d = DONE;
                        end
                    end else begin
                        count_d = count_q - 1'b1;
                    end
                end
            end
            DONE: begin
                if (!run) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        done_d = (state_d == DONE);
        busy_d = (state_d == COUNT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            count_q  <= CNT_W'(DEFAULT_PERIOD);
            period_q <= CNT_W'(DEFAULT_PERIOD);
            mode_q   <= 1'b0;
            tick_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            period_q <= period_d;
            mode_q   <= mode_d;
            tick_q   <= tick_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign tick = tick_q;
    assign done = done_q;
    assign busy = busy_q;

endmodule

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - multi-channel periodic/one-shot tick generator; optional TICK_GEN_PRESCALE_EN prescaler
module tick_gen
    import tick_gen_pkg::*;
#(
    parameter int NUM_CH         = DEF_NUM_CH,
    parameter int CNT_W          = DEF_CNT_W,
    parameter int DEFAULT_PERIOD = DEF_PERIOD,
    parameter int PRESCALE_W     = DEF_PRESCALE_W
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_CH-1:0]             run,
    input  logic [NUM_CH-1:0]             oneshot,
    input  logic                          wr_en,
    input  logic [ch_idx_w(NUM_CH)-1:0]   wr_ch,
    input  logic [CNT_W-1:0]              wr_period,
`ifdef TICK_GEN_PRESCALE_EN
    input  logic [PRESCALE_W-1:0]         prescale_div,
`endif
    output logic [NUM_CH-1:0]             tick,
    output logic [NUM_CH-1:0]             done,
    output logic [NUM_CH-1:0]             busy
);

    logic              strobe;
    logic [NUM_CH-1:0] wr_hit;

`ifdef TICK_GEN_PRESCALE_EN
    logic [PRESCALE_W-1:0] presc_q, presc_d;

    always_comb begin
        presc_d = (presc_q == '0) ? prescale_div : presc_q - 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= prescale_div;
        end else begin
            presc_q <= presc_d;
        end
    end

    assign strobe = (presc_q == '0);
`else
    // Without the prescaler every clock is a count cycle.
    assign strobe = (PRESCALE_W > 0);
`endif

    // Out-of-range channel numbers match no channel and are dropped.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            wr_hit[i] = wr_en && (int'(wr_ch) == i);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        tick_gen_ch #(
            .CNT_W          (CNT_W),
            .DEFAULT_PERIOD (DEFAULT_PERIOD)
        ) u_ch (
            .clk       (clk),
            .reset_n   (reset_n),
            .run       (run[i]),
            .oneshot   (oneshot[i]),
            .strobe    (strobe),
            .wr_hit    (wr_hit[i]),
            .wr_period (wr_period),
            .tick      (tick[i]),
            .done      (done[i]),
            .busy      (busy[i])
        );
    end

endmodule
